post_sparsity_pack: RTL and testbench

POST_SPARSITY_PACK -- requirements
Module: post_sparsity_pack

---
 rtl/post_sparsity_pkg.sv | 24 ++
 rtl/post_sparsity_pack_lane_keep.sv | 25 ++
 rtl/post_sparsity_pack.sv | 104 ++++++++++
 tb/tb_post_sparsity_pack.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/post_sparsity_pkg.sv
// post_sparsity_pkg: shared FSM states, mode encodings and saturating magnitude helper.
package post_sparsity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] MODE_PASS     = 2'b00;
    localparam logic [1:0] MODE_RELU     = 2'b01;
    localparam logic [1:0] MODE_THR      = 2'b10;
    localparam logic [1:0] MODE_RELU_THR = 2'b11;

    localparam int MAG_W = 64;

    // x is a w-bit word sign-extended to MAG_W; the most-negative w-bit value clamps to 2^(w-1)-1
    function automatic logic [MAG_W-1:0] sat_mag(input logic [MAG_W-1:0] x, input int w);
        logic [MAG_W-1:0] lim;
        lim = (MAG_W'(1) << (w - 1)) - MAG_W'(1);
        return !x[MAG_W-1] ? x : (x == ~lim) ? lim : -x;
    endfunction

endpackage

// File: rtl/post_sparsity_pack_lane_keep.sv
// lane_keep: combinational keep decision for one tile word.
module lane_keep
    import post_sparsity_pkg::*;
#(
    parameter int W = 20
) (
    input  logic [W-1:0] i_word,
    input  logic         i_mask_bit,
    input  logic [1:0]   i_mode,
    input  logic [W-1:0] i_thresh,
    output logic         o_keep
);
    logic [MAG_W-1:0] w_mag;
    logic             w_relu;
    logic             w_thr;

    always_comb begin
        w_mag  = sat_mag(MAG_W'($signed(i_word)), W);
        w_relu = i_mode == MODE_RELU || i_mode == MODE_RELU_THR;
        w_thr  = i_mode == MODE_THR || i_mode == MODE_RELU_THR;
        o_keep = i_mask_bit && i_word != '0 && !(w_relu && i_word[W-1])
                 && !(w_thr && w_mag <= MAG_W'(i_thresh));
    end

endmodule

// File: rtl/post_sparsity_pack.sv
// post_sparsity_pack: scans a tile one lane per cycle, compacts kept words and rewrites
// the matching window of the sparsity mask.
module post_sparsity_pack
    import post_sparsity_pkg::*;
#(
    parameter int IL       = 8,
    parameter int FL       = 12,
    parameter int LANES    = 16,
    parameter int length   = 32,
    parameter int p_length = $clog2(length),
    parameter int c_length = $clog2(LANES + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [LANES-1:0][IL+FL-1:0]     i_im,
    input  logic [length-1:0]               i_mask,
    input  logic [p_length-1:0]             i_base,
    input  logic [1:0]                      i_mode,
    input  logic [IL+FL-1:0]                i_thresh,
    input  logic                            input_ready,
    input  logic                            output_taken,
    output logic [LANES-1:0][IL+FL-1:0]     o_im,
    output logic [length-1:0]               o_mask,
    output logic [c_length-1:0]             o_count,
    output logic                            o_valid,
    output logic [1:0]                      state
);
    localparam int W  = IL + FL;
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1;

    if (LANES > length || LANES < 1) begin : g_bad_lanes
        $error("post_sparsity_pack: LANES must be in 1..length");
    end

    state_t                   r_state;
    logic [LANES-1:0][W-1:0]  r_im;
    logic [p_length-1:0]      r_base;
    logic [1:0]               r_mode;
    logic [W-1:0]             r_thresh;
    logic [LW-1:0]            r_idx;

    logic [W-1:0]             w_word;
    logic [p_length:0]        w_sum;
    logic [p_length:0]        w_m;
    logic                     w_keep;

    // Mask window position wraps modulo length, which need not be a power of two
    always_comb begin
        w_word = r_im[r_idx];
        w_sum  = {1'b0, r_base} + (p_length + 1)'(r_idx);
        w_m    = w_sum >= (p_length + 1)'(length) ? w_sum - (p_length + 1)'(length) : w_sum;
    end

    lane_keep #(.W(W)) u_keep (
        .i_word     (w_word),
        .i_mask_bit (o_mask[w_m[p_length-1:0]]),
        .i_mode     (r_mode),
        .i_thresh   (r_thresh),
        .o_keep     (w_keep)
    );

    assign state   = r_state;
    assign o_valid = r_state == DONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_im     <= '0;
            r_base   <= '0;
            r_mode   <= '0;
            r_thresh <= '0;
            r_idx    <= '0;
            o_im     <= '0;
            o_mask   <= '0;
            o_count  <= '0;
        end else begin
            case (r_state)
                IDLE: if (input_ready) begin
                    r_im     <= i_im;
                    r_base   <= i_base;
                    r_mode   <= i_mode;
                    r_thresh <= i_thresh;
                    r_idx    <= '0;
                    o_im     <= '0;
                    o_mask   <= i_mask;
                    o_count  <= '0;
                    r_state  <= SCAN;
                end
                SCAN: begin
                    if (w_keep) begin
                        o_im[o_count[LW-1:0]] <= w_word;
                        o_count               <= o_count + 1'b1;
                    end
                    o_mask[w_m[p_length-1:0]] <= w_keep;
                    r_idx                     <= r_idx + 1'b1;
                    if (r_idx == LW'(LANES - 1)) r_state <= DONE;
                end
                DONE: if (output_taken) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_post_sparsity_pack.sv
// tb_post_sparsity_pack: directed tiles checked against a loop-based keep/compact model.
module tb_post_sparsity_pack;
    localparam int W     = 20;
    localparam int LANES = 16;
    localparam int LEN   = 32;

    typedef logic [LANES-1:0][W-1:0] tile_t;

    logic               clk = 0;
    logic               reset = 1;
    tile_t              i_im = '0;
    logic [LEN-1:0]     i_mask = '0;
    logic [4:0]         i_base = '0;
    logic [1:0]         i_mode = '0;
    logic [W-1:0]       i_thresh = '0;
    logic               input_ready = 0;
    logic               output_taken = 0;
    tile_t              o_im;
    logic [LEN-1:0]     o_mask;
    logic [4:0]         o_count;
    logic               o_valid;
    logic [1:0]         state;

    int                 errors = 0;
    int                 checks = 0;
    tile_t              exp_im;
    logic [LEN-1:0]     exp_mask;
    int                 exp_count;
    bit                 exp_armed = 0;

    post_sparsity_pack dut (
        .clk(clk), .reset(reset), .i_im(i_im), .i_mask(i_mask), .i_base(i_base),
        .i_mode(i_mode), .i_thresh(i_thresh), .input_ready(input_ready),
        .output_taken(output_taken), .o_im(o_im), .o_mask(o_mask), .o_count(o_count),
        .o_valid(o_valid), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic model(input tile_t im, input logic [31:0] mask, input int base,
                         input logic [1:0] mode, input logic [W-1:0] thr);
        exp_im    = '0;
        exp_mask  = mask;
        exp_count = 0;
        for (int i = 0; i < LANES; i++) begin
            int m, v, mag;
            bit k;
            m   = (base + i) % LEN;
            v   = int'($signed(im[i]));
            mag = v < 0 ? -v : v;
            if (mag > 524287) mag = 524287;
            k = mask[m] && v != 0 && !(mode[0] && v < 0) && !(mode[1] && mag <= int'(thr));
            exp_mask[m] = k;
            if (k) begin
                exp_im[exp_count] = im[i];
                exp_count++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (o_valid && exp_armed) begin
            chk("done_state", state, 2'b10);
            chk("o_count", o_count, exp_count);
            chk("o_mask", o_mask, exp_mask);
            chk("o_im", o_im, exp_im);
        end
    end

    task automatic run_tile(input tile_t im, input logic [31:0] mask, input int base,
                            input logic [1:0] mode, input logic [W-1:0] thr);
        int n;
        @(negedge clk);
        i_im = im; i_mask = mask; i_base = 5'(base); i_mode = mode; i_thresh = thr;
        input_ready = 1;
        model(im, mask, base, mode, thr);
        exp_armed = 1;
        @(posedge clk); #1;
        input_ready = 0;
        i_im = '1; i_mask = ~mask; i_mode = ~mode; i_thresh = '0; i_base = ~i_base;
        chk("accept_state", state, 2'b01);
        n = 1;
        while (!o_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, LANES + 1);
    endtask

    task automatic release_tile();
        @(negedge clk);
        output_taken = 1;
        @(posedge clk); #1;
        output_taken = 0;
        chk("release_idle", state, 2'b00);
    endtask

    tile_t t_ramp, t_alt, t_off, t_neg;
    int    n;

    initial begin
        for (int i = 0; i < LANES; i++) begin
            t_ramp[i] = W'(i);
            t_alt[i]  = (i % 2) ? 20'hFFFFB : 20'd5;
            t_off[i]  = W'(i - 8);
            t_neg[i]  = 20'd0;
        end
        t_neg[0] = 20'h80000;

        repeat (2) @(posedge clk); #1;
        chk("rst_state", state, 2'b00);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_count", o_count, 0);
        chk("rst_mask", o_mask, 0);
        chk("rst_im", o_im, 0);
        reset = 0;

        run_tile(t_ramp, 32'hFFFFFFFF, 0, 2'b00, 20'd0);
        chk("ramp_count", o_count, 15);
        chk("ramp_mask", o_mask, 32'hFFFFFFFE);
        chk("ramp_im0", o_im[0], 1);
        chk("ramp_im14", o_im[14], 15);
        chk("ramp_im15", o_im[15], 0);
        release_tile();

        run_tile(t_alt, 32'hFFFFFFFF, 0, 2'b01, 20'd0);
        chk("relu_count", o_count, 8);
        chk("relu_mask", o_mask, 32'hFFFF5555);
        chk("relu_im7", o_im[7], 5);
        chk("relu_im8", o_im[8], 0);
        release_tile();

        run_tile(t_off, 32'hFFFFFFFF, 28, 2'b11, 20'd3);
        chk("wrap_count", o_count, 4);
        chk("wrap_mask", o_mask, 32'h0FFFFF00);
        chk("wrap_im0", o_im[0], 4);
        chk("wrap_im3", o_im[3], 7);
        release_tile();

        run_tile(t_neg, 32'hFFFFFFFF, 0, 2'b10, 20'h7FFFF);
        chk("sat_count", o_count, 0);
        chk("sat_mask", o_mask, 32'hFFFF0000);
        release_tile();

        exp_armed = 0;
        @(negedge clk);
        i_im = t_alt; i_mask = 32'hFFFFFFFF; i_base = 5'd3; i_mode = 2'b00;
        input_ready = 1;
        @(posedge clk); #1;
        input_ready = 0;
        repeat (4) @(posedge clk);
        #1 reset = 1;
        #1;
        chk("abort_state", state, 2'b00);
        chk("abort_mask", o_mask, 0);
        chk("abort_count", o_count, 0);
        chk("abort_valid", o_valid, 1'b0);
        chk("abort_im", o_im, 0);
        @(posedge clk); #1 reset = 0;
        run_tile(t_ramp, 32'hFFFFFFFF, 0, 2'b00, 20'd0);
        chk("fresh_count", o_count, 15);
        chk("fresh_mask", o_mask, 32'hFFFFFFFE);

        @(negedge clk);
        i_im = t_off; i_mask = 32'hFFFFFFFF; i_base = 5'd28; i_mode = 2'b11; i_thresh = 20'd3;
        input_ready = 1;
        output_taken = 1;
        @(posedge clk); #1;
        output_taken = 0;
        chk("both_state", state, 2'b00);
        chk("both_count_held", o_count, 15);
        chk("both_mask_held", o_mask, 32'hFFFFFFFE);
        model(t_off, 32'hFFFFFFFF, 28, 2'b11, 20'd3);
        @(posedge clk); #1;
        input_ready = 0;
        chk("both_accept", state, 2'b01);
        n = 1;
        while (!o_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("both_latency", n, LANES + 1);
        chk("both_count", o_count, 4);
        release_tile();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
